// File: rtl/data_memory_ls.sv
// data_memory_ls: word-organised data memory with byte/half/word load-store, self-clear after reset
// and a fixed-latency response pipeline (RD_LAT 1 or 2).
module data_memory_ls #(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W+1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              init_done_o
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("data_memory_ls: RD_LAT must be 1 or 2");
        end
    endgenerate

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [31:0]       mem [DEPTH];
    logic              acc;
    logic              err;
    logic [ADDR_W-1:0] widx;
    logic [1:0]        lane;
    logic [31:0]       word;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;
    logic [31:0]       ld;
    logic [31:0]       rsp_d;
    logic [3:0]        be;
    logic [31:0]       wrep;

    assign req_ready_o = state == RUN;
    assign init_done_o = state == RUN;
    assign acc         = req_valid_i && req_ready_o;
    assign widx        = req_addr_i[ADDR_W+1:2];
    assign lane        = req_addr_i[1:0];
    assign err         = req_size_i == 2'b11 || (req_size_i == 2'b01 && lane[0]) ||
                         (req_size_i == 2'b00 && lane != 2'b00);
    assign word        = mem[widx];

    // Store data is replicated across lanes so the byte enables alone pick the destination.
    always_comb begin
        sel_b = word[{lane, 3'b000} +: 8];
        sel_h = lane[1] ? word[31:16] : word[15:0];
        ld    = req_size_i == 2'b00 ? word :
                req_size_i == 2'b01 ? {{16{sel_h[15] & ~req_unsigned_i}}, sel_h} :
                                      {{24{sel_b[7] & ~req_unsigned_i}}, sel_b};
        rsp_d = (err || req_we_i) ? 32'h0 : ld;
        be    = req_size_i == 2'b00 ? 4'b1111 :
                req_size_i == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lane;
        wrep  = req_size_i == 2'b00 ? req_wdata_i :
                req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : {4{req_wdata_i[7:0]}};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
            if (&cnt) state <= RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (acc && req_we_i && !err) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[widx][8*i +: 8] <= wrep[8*i +: 8];
        end
    end

    logic        s1_v;
    logic        s1_e;
    logic [31:0] s1_d;

    // Data/err registers load only with a response so they hold between pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v <= 1'b0;
            s1_e <= 1'b0;
            s1_d <= '0;
        end else begin
            s1_v <= acc;
            if (acc) begin
                s1_e <= err;
                s1_d <= rsp_d;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic        s2_v;
            logic        s2_e;
            logic [31:0] s2_d;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    s2_v <= 1'b0;
                    s2_e <= 1'b0;
                    s2_d <= '0;
                end else begin
                    s2_v <= s1_v;
                    if (s1_v) begin
                        s2_e <= s1_e;
                        s2_d <= s1_d;
                    end
                end
            end
            assign rsp_valid_o = s2_v;
            assign rsp_err_o   = s2_e;
            assign rsp_rdata_o = s2_d;
        end else begin : g_lat1
            assign rsp_valid_o = s1_v;
            assign rsp_err_o   = s1_e;
            assign rsp_rdata_o = s1_d;
        end
    endgenerate
endmodule

// File: tb/tb_data_memory_ls.sv
// tb_data_memory_ls: drives one RD_LAT=1 and one RD_LAT=2 instance (ADDR_W=4) with identical requests
// and checks responses against a byte-array reference model.
module tb_data_memory_ls;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  ready;
    logic [1:0]  done;
    logic [1:0]  rvalid;
    logic [1:0]  rerr;
    logic [31:0] rdata [2];

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t       got [2][$];
    rsp_t       exp_q [$];
    logic [7:0] mb [64];

    data_memory_ls #(.ADDR_W(4), .RD_LAT(1)) u_lat1 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(ready[0]),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rvalid[0]), .rsp_rdata_o(rdata[0]), .rsp_err_o(rerr[0]),
        .init_done_o(done[0])
    );

    data_memory_ls #(.ADDR_W(4), .RD_LAT(2)) u_lat2 (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(ready[1]),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rvalid[1]), .rsp_rdata_o(rdata[1]), .rsp_err_o(rerr[1]),
        .init_done_o(done[1])
    );

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i)
        for (int d = 0; d < 2; d++)
            if (rvalid[d]) got[d].push_back({32'(cyc), rdata[d], rerr[d]});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    // Memory viewed as little-endian bytes; sign extension is done arithmetically.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns, input logic [5:0] a,
                         input logic [31:0] wd, output logic [31:0] d, output logic e);
        int n;
        n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        e = (sz == 2'd3) || (int'(a) % n != 0);
        d = 32'h0;
        if (!e && we) begin
            for (int i = 0; i < n; i++) mb[int'(a) + i] = wd[8*i +: 8];
        end else if (!e) begin
            for (int i = 0; i < n; i++) d = d + (32'(mb[int'(a) + i]) << (8 * i));
            if (!uns && n < 4 && d[8*n-1]) d = d - (32'd1 << (8 * n));
        end
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic uns, input logic [5:0] a,
                        input logic [31:0] wd);
        logic [31:0] d;
        logic        e;
        @(negedge clk_i);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = sz;
        req_uns   = uns;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk_i);
        #1;
        req_valid = 1'b0;
        model(we, sz, uns, a, wd, d, e);
        exp_q.push_back({32'(cyc), d, e});
    endtask

    task automatic flush();
        got[0].delete();
        got[1].delete();
        exp_q.delete();
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_i);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!done[0] && n < 64) begin
            @(posedge clk_i);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        rst_i = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'd0;
        req_uns = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        #23;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({rvalid[d], rerr[d], ready[d], done[d], rdata[d]} !== 36'h0) begin
                miscompares++;
                $display("FAIL reset_outputs lat%0d: valid=%b err=%b ready=%b done=%b rdata=%h, want all 0",
                         d + 1, rvalid[d], rerr[d], ready[d], done[d], rdata[d]);
            end
        end
        foreach (mb[i]) mb[i] = 8'h0;
        flush();
        @(negedge clk_i);
        rst_i = 1'b0;
        req_valid = 1'b1;
        wait_init(n);
        req_valid = 1'b0;
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL init_edges: init_done after %0d edges, want 16", n);
        end
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({done[d], ready[d]} !== 2'b11) begin
                miscompares++;
                $display("FAIL init_flags lat%0d: done=%b ready=%b, want 1 1", d + 1, done[d], ready[d]);
            end
        end
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 0) begin
                miscompares++;
                $display("FAIL clear_ignore lat%0d: %0d responses during clear, want 0", d + 1, got[d].size());
            end
        end
        for (int w = 0; w < 16; w++) send(1'b0, 2'd0, 1'b0, 6'(w * 4), 32'h0);
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 16) begin
                miscompares++;
                $display("FAIL clear_read_count lat%0d: %0d responses, want 16", d + 1, got[d].size());
            end else for (int i = 0; i < 16; i++) begin
                vectors++;
                if (got[d][i].data !== 32'h0 || got[d][i].err !== 1'b0 || got[d][i].cyc !== exp_q[i].cyc + 32'(d)) begin
                    miscompares++;
                    $display("FAIL clear_read lat%0d word%0d: data=%h err=%b cyc=%0d, want 00000000 0 cyc=%0d",
                             d + 1, i, got[d][i].data, got[d][i].err, got[d][i].cyc, exp_q[i].cyc + 32'(d));
                end
            end
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] k [5];
        k = '{32'h0, 32'hFFFFFFF0, 32'h00000080, 32'hFFFF8000, 32'h000080F0};
        flush();
        send(1'b1, 2'd0, 1'b0, 6'h08, 32'h800080F0);
        send(1'b0, 2'd2, 1'b0, 6'h08, 32'h0);
        send(1'b0, 2'd2, 1'b1, 6'h09, 32'h0);
        repeat (2) @(negedge clk_i);
        send(1'b0, 2'd1, 1'b0, 6'h0A, 32'h0);
        send(1'b0, 2'd1, 1'b1, 6'h08, 32'h0);
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 5) begin
                miscompares++;
                $display("FAIL load_ext_count lat%0d: %0d responses, want 5", d + 1, got[d].size());
            end else for (int i = 0; i < 5; i++) begin
                vectors++;
                if (got[d][i].data !== k[i] || got[d][i].err !== 1'b0 || got[d][i].cyc !== exp_q[i].cyc + 32'(d)) begin
                    miscompares++;
                    $display("FAIL load_ext lat%0d #%0d: data=%h err=%b cyc=%0d, want %h 0 cyc=%0d",
                             d + 1, i, got[d][i].data, got[d][i].err, got[d][i].cyc, k[i], exp_q[i].cyc + 32'(d));
                end
            end
            vectors++;
            if (rdata[d] !== 32'h000080F0) begin
                miscompares++;
                $display("FAIL rdata_hold lat%0d: idle rdata=%h, want 000080f0", d + 1, rdata[d]);
            end
        end
    endtask

    task automatic test_store_merge();
        flush();
        send(1'b1, 2'd0, 1'b0, 6'h04, 32'h11223344);
        send(1'b1, 2'd2, 1'b0, 6'h05, 32'h000000AB);
        send(1'b1, 2'd1, 1'b0, 6'h06, 32'h0000BEEF);
        send(1'b0, 2'd0, 1'b0, 6'h04, 32'h0);
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 4) begin
                miscompares++;
                $display("FAIL merge_count lat%0d: %0d responses, want 4", d + 1, got[d].size());
            end else for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got[d][i].data !== (i == 3 ? 32'hBEEFAB44 : 32'h0) || got[d][i].err !== 1'b0 ||
                    got[d][i].cyc !== exp_q[i].cyc + 32'(d)) begin
                    miscompares++;
                    $display("FAIL store_merge lat%0d #%0d: data=%h err=%b cyc=%0d, want %h 0 cyc=%0d",
                             d + 1, i, got[d][i].data, got[d][i].err, got[d][i].cyc,
                             (i == 3 ? 32'hBEEFAB44 : 32'h0), exp_q[i].cyc + 32'(d));
                end
            end
        end
    endtask

    task automatic test_errors();
        flush();
        send(1'b0, 2'd1, 1'b0, 6'h03, 32'h0);
        send(1'b1, 2'd0, 1'b0, 6'h06, 32'hDEADBEEF);
        send(1'b0, 2'd3, 1'b0, 6'h00, 32'h0);
        send(1'b0, 2'd0, 1'b0, 6'h04, 32'h0);
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 4) begin
                miscompares++;
                $display("FAIL err_count lat%0d: %0d responses, want 4", d + 1, got[d].size());
            end else for (int i = 0; i < 4; i++) begin
                vectors++;
                if (got[d][i].data !== (i == 3 ? 32'hBEEFAB44 : 32'h0) || got[d][i].err !== (i != 3) ||
                    got[d][i].cyc !== exp_q[i].cyc + 32'(d)) begin
                    miscompares++;
                    $display("FAIL errors lat%0d #%0d: data=%h err=%b cyc=%0d, want %h %b cyc=%0d",
                             d + 1, i, got[d][i].data, got[d][i].err, got[d][i].cyc,
                             (i == 3 ? 32'hBEEFAB44 : 32'h0), (i != 3), exp_q[i].cyc + 32'(d));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        flush();
        send(1'b1, 2'd0, 1'b0, 6'h0C, 32'hCAFEF00D);
        send(1'b0, 2'd0, 1'b0, 6'h0C, 32'h0);
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 2) begin
                miscompares++;
                $display("FAIL b2b_count lat%0d: %0d responses, want 2", d + 1, got[d].size());
            end else for (int i = 0; i < 2; i++) begin
                vectors++;
                if (got[d][i].data !== (i == 1 ? 32'hCAFEF00D : 32'h0) || got[d][i].err !== 1'b0 ||
                    got[d][i].cyc !== exp_q[0].cyc + 32'(d + i)) begin
                    miscompares++;
                    $display("FAIL back_to_back lat%0d #%0d: data=%h err=%b cyc=%0d, want %h 0 cyc=%0d",
                             d + 1, i, got[d][i].data, got[d][i].err, got[d][i].cyc,
                             (i == 1 ? 32'hCAFEF00D : 32'h0), exp_q[0].cyc + 32'(d + i));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] sz;
        logic [5:0] a;
        int n;
        flush();
        repeat (300) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
            n  = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
            a  = 6'($urandom % 64);
            if ($urandom % 4 != 0) a = 6'((int'(a) / n) * n);
            send(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom);
        end
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL random_count lat%0d: %0d responses, want %0d", d + 1, got[d].size(), exp_q.size());
            end else for (int i = 0; i < exp_q.size(); i++) begin
                vectors++;
                if (got[d][i].data !== exp_q[i].data || got[d][i].err !== exp_q[i].err ||
                    got[d][i].cyc !== exp_q[i].cyc + 32'(d)) begin
                    miscompares++;
                    $display("FAIL random lat%0d #%0d: data=%h err=%b cyc=%0d, want %h %b cyc=%0d",
                             d + 1, i, got[d][i].data, got[d][i].err, got[d][i].cyc,
                             exp_q[i].data, exp_q[i].err, exp_q[i].cyc + 32'(d));
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        int n;
        flush();
        send(1'b0, 2'd0, 1'b0, 6'h0C, 32'h0);
        send(1'b0, 2'd0, 1'b0, 6'h08, 32'h0);
        rst_i = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if ({rvalid[d], rerr[d], ready[d], done[d], rdata[d]} !== 36'h0) begin
                miscompares++;
                $display("FAIL inflight_reset_outputs lat%0d: valid=%b err=%b ready=%b done=%b rdata=%h, want all 0",
                         d + 1, rvalid[d], rerr[d], ready[d], done[d], rdata[d]);
            end
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        foreach (mb[i]) mb[i] = 8'h0;
        wait_init(n);
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL reinit_edges: init_done after %0d edges, want 16", n);
        end
        // Only the RD_LAT=1 instance had already emitted the first load before reset.
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 1 - d) begin
                miscompares++;
                $display("FAIL inflight_discard lat%0d: %0d responses, want %0d", d + 1, got[d].size(), 1 - d);
            end
        end
        flush();
        send(1'b0, 2'd0, 1'b0, 6'h0C, 32'h0);
        settle();
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (got[d].size() != 1 || got[d][0].data !== 32'h0 || got[d][0].err !== 1'b0 ||
                got[d][0].cyc !== exp_q[0].cyc + 32'(d)) begin
                miscompares++;
                $display("FAIL post_reset_read lat%0d: %0d responses, first data=%h, want 1 response 00000000",
                         d + 1, got[d].size(), got[d].size() > 0 ? got[d][0].data : 32'hx);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_merge();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
